// File: rtl/mull_sequencer.sv
// Sequential 32x32->64 UMULL/SMULL: shift-and-add over operand magnitudes, sign applied at the end.
// Optional MULL_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are all zero.
module mull_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] res_hi_q, res_hi_d;

  logic [31:0] mag_a, mag_b;
  logic [63:0] acc_sum, product;
  logic        last_iter;

  // Two's-complement negate of 0x80000000 wraps back to 0x80000000, which is the correct magnitude.
  assign mag_a   = (is_signed & a[31]) ? (~a + 32'd1) : a;
  assign mag_b   = (is_signed & b[31]) ? (~b + 32'd1) : b;
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign product = neg_q ? (~acc_sum + 64'd1) : acc_sum;

`ifdef MULL_EARLY_TERM_EN
  assign last_iter = (mplier_q[31:1] == 31'd0) || (cnt_q == 6'd31);
`else
  assign last_iter = (cnt_q == 6'd31);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {32'd0, mag_a};
          mplier_d = mag_b;
          acc_d    = 64'd0;
          cnt_d    = 6'd0;
          neg_d    = is_signed & (a[31] ^ b[31]);
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 6'd1;
        if (last_iter) begin
          res_lo_d = product[31:0];
          res_hi_d = product[63:32];
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign stall     = ((state_q == IDLE) & start) | (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_mull_sequencer.sv
// Directed bench for mull_sequencer: vector table of long multiplies plus reset-abort and held-start sequences.
module tb_mull_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        stall, busy, done;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  mull_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .stall(stall), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected edges from the start edge to the edge that enters DONE, inclusive.
  function automatic int exp_lat(input logic sgn, input logic [31:0] bb);
`ifdef MULL_EARLY_TERM_EN
    logic [31:0] m;
    int hib;
    m = (sgn && bb[31]) ? (~bb + 32'd1) : bb;
    hib = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hib = i + 1;
    return 1 + ((hib < 1) ? 1 : hib);
`else
    return 33 + ((sgn & bb[0]) & 1'b0);
`endif
  endfunction

  // Called at posedge+1 right after the start edge; returns edges counted including the start edge.
  task automatic wait_done(output int lat, output bit got);
    lat = 1;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_40");
    end
  endtask

  task automatic do_mul(input logic sgn, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ehi, input logic [31:0] elo, input int idx);
    int lat;
    bit got;
    is_signed = sgn; a = aa; b = bb; start = 1'b1;
    #1;
    chk("stall_idle_start", {63'd0, stall}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("stall_in_run", {63'd0, stall}, 64'd1);
    wait_done(lat, got);
    if (got) begin
      chk("latency", 64'(lat), 64'(exp_lat(sgn, bb)));
      chk("product", {result_hi, result_lo}, {ehi, elo});
      chk("stall_in_done", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
      chk("result_hold", {result_hi, result_lo}, {ehi, elo});
    end
    $display("vec %0d sgn=%0b a=%h b=%h -> hi=%h lo=%h lat=%0d", idx, sgn, aa, bb, result_hi, result_lo, lat);
  endtask

  initial begin
    int lat;
    bit got;
    int pulses;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[3] = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[4] = '{1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[7] = '{1'b1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988};
    vecs[8] = '{1'b0, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF};
    vecs[9] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};

    #12;
    chk("reset_state", {result_hi, result_lo}, 64'd0);
    chk("reset_flags", {61'd0, done, busy, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      do_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, i);

    // Reset abort mid-RUN, while a nonzero product from the table is still held.
    is_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_abort", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_results", {result_hi, result_lo}, 64'd0);
    chk("abort_flags", {61'd0, done, busy, stall}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("no_done_after_abort", 64'(pulses), 64'd0);
    $display("abort sequence done_pulses=%0d", pulses);
    do_mul(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 10);

    // start held high through RUN; operand changes mid-RUN must be ignored.
    is_signed = 1'b0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    a = 32'hFFFFFFFF; b = 32'd2;
    wait_done(lat, got);
    if (got) begin
      chk("held_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd5)));
      chk("held_product", {result_hi, result_lo}, 64'd15);
      chk("held_stall_done", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      chk("held_idle", {62'd0, done, busy}, 64'd0);
      chk("held_stall_idle", {63'd0, stall}, 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_from_idle", {63'd0, busy}, 64'd1);
      wait_done(lat, got);
      if (got) chk("second_product", {result_hi, result_lo}, 64'h1_FFFFFFFE);
    end
    $display("held-start sequence hi=%h lo=%h", result_hi, result_lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mull_sequencer.md
MULL_SEQUENCER -- requirements
Module: mull_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
REQ-002 The block SHALL have these further ports:
- start  input  1  request a 32x32->64 long multiply (UMULL/SMULL).
- is_signed  input  1  1 = SMULL (two's complement), 0 = UMULL; sampled with start.
- a  input  32  multiplicand (Rn); sampled with start.
- b  input  32  multiplier (Rm); sampled with start.
- stall  output  1  holds processor PC/pipeline while the multiply is in flight.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- result_lo  output  32  product bits [31:0] (RdLo).
- result_hi  output  32  product bits [63:32] (RdHi).

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE only.
REQ-004 In IDLE with start=1, the rising edge SHALL capture operand magnitudes, the sign flag (is_signed & (a[31]^b[31])) and a zeroed 64-bit accumulator, then enter RUN with iteration count 0.
REQ-005 In IDLE with start=0, the FSM SHALL remain in IDLE and hold result_lo/result_hi.
REQ-006 Each RUN edge SHALL examine one multiplier bit, LSB first, add the shifted multiplicand to the accumulator when the bit is 1, and increment the count.
REQ-007 After the 32nd RUN edge, the FSM SHALL load result_hi:result_lo with the product and enter DONE; the product is the accumulator, two's-complement negated over 64 bits when the sign flag is set.
REQ-008 DONE SHALL last exactly one cycle with done=1 and then return to IDLE unconditionally.
REQ-009 Latency SHALL be: start sampled at edge E0 -> done high in the cycle following edge E32 (33 edges, default build).
REQ-010 In signed mode, operand magnitudes SHALL be formed as the 32-bit unsigned absolute value; 0x80000000 SHALL yield magnitude 0x80000000 with no overflow.
REQ-011 stall SHALL equal (state==IDLE & start) | (state==RUN), combinationally; stall SHALL be 0 in DONE so the processor retires using the valid result.
REQ-012 start asserted in RUN or DONE SHALL be ignored and SHALL NOT alter operands, count or sign flag.
REQ-013 result_lo/result_hi SHALL change only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-014 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-015 reset=0 SHALL immediately force IDLE, count=0, accumulator=0, result_lo=0, result_hi=0, done=0 and busy=0, including mid-RUN; an aborted multiply SHALL produce no done pulse.
REQ-016 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-017 When macro MULL_EARLY_TERM_EN is defined, RUN SHALL exit to DONE on the edge after which the remaining unshifted multiplier bits are all zero, with a minimum of 1 RUN edge; latency is then 1 + max(1, index of highest set magnitude bit + 1) edges to DONE.
REQ-018 When MULL_EARLY_TERM_EN is undefined, RUN SHALL always take exactly 32 edges; products SHALL be identical in both builds.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- UMULL a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start (default build).
- SMULL a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- SMULL a=7, b=0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MULL_EARLY_TERM_EN, the same product.
- UMULL a=0x12345678, b=0 -> hi=0, lo=0; with MULL_EARLY_TERM_EN, done 2 edges after start.
- Reset pulsed low at RUN count 10 -> all outputs 0 at once and no done pulse; a following UMULL a=3, b=5 -> lo=15, hi=0.
- start held high through RUN -> single done pulse; stall=0 in DONE; a second multiply starts only from IDLE.
